// File: rtl/spi_slave_regs.sv
// SPI mode-0 responder: oversamples SCLK/CS_n/MOSI in the clk domain and turns
// 32-bit {RW, addr[14:0], data[15:0]} frames into register-bus reads and writes.
module spi_slave_regs #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    output logic [14:0] addr,
    output logic        rd_req,
    input  logic [15:0] rd_data,
    output logic [15:0] wr_data,
    output logic        wr_stb,
    output logic        busy,
    output logic        frame_err
);

    typedef enum logic [2:0] {IDLE, CMD, RLOAD, DATA, HOLD} state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] vld_q, vld_d;
    logic                   sclk_prev_q, sclk_prev_d;

    logic [5:0]  cnt_q, cnt_d;
    logic [15:0] rx_q, rx_d;
    logic [15:0] tx_q, tx_d;
    logic        rw_q, rw_d;
    logic [14:0] addr_q, addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        miso_q, miso_d;
    logic        rd_req_q, rd_req_d;
    logic        wr_stb_q, wr_stb_d;
    logic        frame_err_q, frame_err_d;
    logic        armed_q, armed_d;

    logic        sclk_s, cs_n_s, mosi_s;
    logic        sclk_rise, sclk_fall, cs_abort;
    logic [15:0] rx_next;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_n_s    = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_abort  = (state_q != IDLE) && cs_n_s;
    assign rx_next   = {rx_q[14:0], mosi_s};

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        vld_d       = {vld_q[SYNC_STAGES-2:0], 1'b1};
        sclk_prev_d = sclk_s;
    end

    // The CS_n chain resets high so the pad stays disabled; vld_q marks when the
    // chain holds real pin samples, so only a genuine high can arm the block.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            vld_q       <= '0;
            sclk_prev_q <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wr_data_q   <= '0;
            miso_q      <= 1'b0;
            rd_req_q    <= 1'b0;
            wr_stb_q    <= 1'b0;
            frame_err_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            vld_q       <= vld_d;
            sclk_prev_q <= sclk_prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wr_data_q   <= wr_data_d;
            miso_q      <= miso_d;
            rd_req_q    <= rd_req_d;
            wr_stb_q    <= wr_stb_d;
            frame_err_q <= frame_err_d;
            armed_q     <= armed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (armed_q && !cs_n_s) state_d = CMD;
            CMD:   if (sclk_rise && cnt_q == 6'd15) state_d = rx_next[15] ? RLOAD : DATA;
            RLOAD: if (!rd_req_q) state_d = DATA;
            DATA:  if (sclk_rise && cnt_q == 6'd31) state_d = HOLD;
            HOLD:  state_d = HOLD;
            default: state_d = IDLE;
        endcase
        if (cs_abort) state_d = IDLE;
    end

    // RLOAD spends the rd_req cycle waiting so rd_data is taken one clk later.
    always_comb begin
        cnt_d       = cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        wr_data_d   = wr_data_q;
        miso_d      = miso_q;
        rd_req_d    = 1'b0;
        wr_stb_d    = 1'b0;
        frame_err_d = 1'b0;
        armed_d     = armed_q | (vld_q[SYNC_STAGES-1] & cs_n_s);
        if (cs_abort) begin
            cnt_d       = '0;
            rx_d        = '0;
            tx_d        = '0;
            miso_d      = 1'b0;
            frame_err_d = (cnt_q != 6'd0) && (cnt_q < 6'd32);
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d  = '0;
                    tx_d   = '0;
                    miso_d = 1'b0;
                end
                CMD: begin
                    if (sclk_rise) begin
                        rx_d  = rx_next;
                        cnt_d = cnt_q + 6'd1;
                        if (cnt_q == 6'd15) begin
                            addr_d   = rx_next[14:0];
                            rw_d     = rx_next[15];
                            rd_req_d = rx_next[15];
                        end
                    end
                end
                RLOAD: begin
                    if (!rd_req_q) tx_d = rd_data;
                end
                DATA: begin
                    if (sclk_fall) begin
                        miso_d = tx_q[15];
                        tx_d   = {tx_q[14:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        rx_d  = rx_next;
                        cnt_d = cnt_q + 6'd1;
                        if (cnt_q == 6'd31 && !rw_q) begin
                            wr_data_d = rx_next;
                            wr_stb_d  = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    miso_d = 1'b0;
                    cnt_d  = 6'd32;
                end
                default: cnt_d = '0;
            endcase
        end
    end

    always_comb begin
        miso      = miso_q;
        miso_oe   = ~cs_n_s;
        addr      = addr_q;
        rd_req    = rd_req_q;
        wr_data   = wr_data_q;
        wr_stb    = wr_stb_q;
        busy      = (state_q != IDLE);
        frame_err = frame_err_q;
    end

endmodule

// File: doc/spi_slave_regs.md
# spi_slave_regs

SPI responder, the target end of the team's SPI master link. It deserializes 32-bit mode-0 frames of the form {RW, addr[14:0], data[15:0]} into register-bus write strobes and read requests, and serializes read data back on MISO. It sits between the external SPI pins and a local register file, in the system `clk` domain. SCLK, CS_n and MOSI are asynchronous to `clk` and are oversampled.

## Interface

Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth on `sclk`, `cs_n` and `mosi`. Minimum 2.

Ports:
- `clk`  in  1: system clock; every flop is in this domain.
- `reset`  in  1: asynchronous, active-low reset.
- `sclk`  in  1: SPI clock from the master, CPOL=0, CPHA=0.
- `cs_n`  in  1: chip select, active low.
- `mosi`  in  1: serial data from the master, MSB first.
- `miso`  out  1: serial data to the master, MSB first.
- `miso_oe`  out  1: pad enable; equals synchronized `~cs_n`.
- `addr`  out  15: address latched from the command word.
- `rd_req`  out  1: one-`clk` pulse; requests `rd_data` for `addr`.
- `rd_data`  in  16: read data; must be valid on the `clk` cycle after `rd_req`.
- `wr_data`  out  16: write data; valid while `wr_stb` is high.
- `wr_stb`  out  1: one-`clk` pulse at the end of a complete write frame.
- `busy`  out  1: high from frame start until CS_n deasserts.
- `frame_err`  out  1: one-`clk` pulse when CS_n rises with 0 < bit count < 32.

## Operation

Input path:
- Each of `sclk`, `cs_n`, `mosi` passes through `SYNC_STAGES` flops.
- One extra flop on synced `sclk` gives the rise and fall detects.

Frame format:
- Bit 31 = RW (1 = read), bits 30:16 = addr, bits 15:0 = data.
- MOSI is sampled on SCLK rise. MISO changes on SCLK fall.

State machine: IDLE, CMD, RLOAD, DATA, HOLD.
- **IDLE:** `miso`=0, bit counter = 0. Synced `cs_n` falling goes to CMD; `busy`=1.
- **CMD:** shift MOSI on each rise. On the 16th rise, latch `addr` and RW.
  - RW=1: pulse `rd_req`, go to RLOAD.
  - RW=0: go to DATA.
- **RLOAD:** on the next `clk`, load `rd_data` into the TX shifter, go to DATA.
- **DATA:**
  - Each fall drives the TX shifter MSB on `miso`, then shifts left.
  - For writes `miso` stays 0.
  - Each rise shifts MOSI into the RX shifter.
  - On the 32nd rise: write frames latch `wr_data` and pulse `wr_stb` on the same `clk`; read frames do nothing. Go to HOLD.
- **HOLD:** ignore SCLK. Keep `miso`=0 and the counter saturated at 32.
- **Any state:** synced `cs_n` high returns to IDLE and clears `busy`.
  - Pulse `frame_err` if the counter was between 1 and 31.
  - A partial frame never produces `wr_stb`.
  - A partial read frame may already have issued `rd_req`; reads have no side effects.

Widths: bit counter is 6 bits and saturates at 32. Extra SCLK edges past 32 never wrap into a second frame.

Reset (`reset`=0) forces immediately, mid-frame or not:
- IDLE;
- `miso`=0, `miso_oe`=0;
- `rd_req`=0, `wr_stb`=0, `frame_err`=0, `busy`=0;
- `addr`=0, `wr_data`=0, shifters=0, counter=0.

After reset release the block waits for synced `cs_n` high before accepting a new CS_n fall. This prevents a half-frame.

## Timing

- Input latency is `SYNC_STAGES`+1 `clk` from a pin edge to the internal edge detect.
- Minimum SCLK period is 8 `clk` (high ≥4, low ≥4). This covers the read turnaround from rise 16 to the MISO update on fall 16: sync + `rd_req` + load + drive ≤ 4 `clk` for `SYNC_STAGES`=2.
- `wr_stb` arrives `SYNC_STAGES`+1 `clk` after the 32nd SCLK rise at the pin.
- CS_n high time between frames is ≥ 4 `clk`. CS_n fall to first SCLK rise is ≥ 4 `clk`.
- `rd_data` is sampled exactly one `clk` after `rd_req`.
- When CS_n rises on the same `clk` as a detected SCLK edge, CS_n wins: the edge is discarded.

## Test plan

1. **Write frame.** Send 0x0012_ABCD at SCLK = `clk`/8. Expect one `wr_stb` pulse with `addr`=0x012, `wr_data`=0xABCD, no `rd_req`, no `frame_err`, and `miso`=0 throughout.
2. **Read frame.** Send 0x8034_0000 with the model returning 0x1234 one `clk` after `rd_req`. Expect exactly one `rd_req` with `addr`=0x034, the master capturing 0x1234 on bits 15:0, and no `wr_stb`.
3. **Aborted frame.** Raise CS_n after 10 bits. Expect one `frame_err` pulse, no `wr_stb`, `busy` low. A following write of 0x0001_5555 then completes normally.
4. **Over-long frame.** Write 0x0007_00FF followed by 8 extra SCLK cycles. Expect a single `wr_stb` with `wr_data`=0x00FF, `miso`=0 during the extra bits, and no `frame_err`.
5. **Reset mid-frame.** Assert `reset` after 20 bits of a write. Expect all outputs 0 immediately and no `wr_stb` after release. With CS_n still low, the remaining SCLKs are ignored until CS_n cycles high.
6. **Back-to-back frames.** Send a write then a read with CS_n high for exactly 4 `clk` between them. Expect both frames decoded correctly and no `frame_err`.
